// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand sequencer: status one-hot codes,
// sequencer state encoding and a one-hot test helper.
package fpu_pkg;

  localparam logic [3:0] StatusExact     = 4'b0001;
  localparam logic [3:0] StatusOverflow  = 4'b0010;
  localparam logic [3:0] StatusUnderflow = 4'b0100;
  localparam logic [3:0] StatusInexact   = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } seq_state_t;

  function automatic logic is_onehot4(input logic [3:0] s);
    return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/status_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module status_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Operand issue / result capture wrapper around the FPU with a fixed settle
// latency, single-entry result register and per-status event counters.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic [31:0]      a_in,
  input  logic [31:0]      b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      op_A_out,
  output logic [31:0]      op_B_out,
  input  logic [31:0]      fpu_data_in,
  input  logic [3:0]       fpu_status_in,
  input  logic             fpu_flags_in,
  output logic [31:0]      res_data_out,
  output logic [3:0]       res_status_out,
  output logic             res_flags_out,
  output logic             res_valid,
  input  logic             res_ready,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_exact_out,
  output logic [CNT_W-1:0] cnt_ovf_out,
  output logic [CNT_W-1:0] cnt_unf_out,
  output logic [CNT_W-1:0] cnt_inx_out,
  output logic             status_err_out
);

  if (LATENCY < 1) begin : g_latency_check
    $error("fpu_op_sequencer: LATENCY must be at least 1");
  end

  localparam int unsigned WaitW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  seq_state_t       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             load;
  logic             capture;

  logic [31:0] op_a_q, op_b_q;
  logic [31:0] res_data_q;
  logic [3:0]  res_status_q;
  logic        res_flag_q;
  logic        status_err_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          wait_d  = WaitW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = StHold;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StHold: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Operands only move on an accepted input so the FPU sees a stable pair.
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (load) begin
      op_a_q <= a_in;
      op_b_q <= b_in;
    end
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      res_data_q   <= '0;
      res_status_q <= '0;
      res_flag_q   <= 1'b0;
    end else if (capture) begin
      res_data_q   <= fpu_data_in;
      res_status_q <= fpu_status_in;
      res_flag_q   <= fpu_flags_in;
    end
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      status_err_q <= 1'b0;
    end else if (clear_cnt) begin
      status_err_q <= 1'b0;
    end else if (capture && !is_onehot4(fpu_status_in)) begin
      status_err_q <= 1'b1;
    end
  end

  status_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_exact (
    .clk  (clock100KHz),
    .rst  (reset),
    .clear(clear_cnt),
    .inc  (capture && (fpu_status_in == StatusExact)),
    .count(cnt_exact_out)
  );

  status_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_ovf (
    .clk  (clock100KHz),
    .rst  (reset),
    .clear(clear_cnt),
    .inc  (capture && (fpu_status_in == StatusOverflow)),
    .count(cnt_ovf_out)
  );

  status_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_unf (
    .clk  (clock100KHz),
    .rst  (reset),
    .clear(clear_cnt),
    .inc  (capture && (fpu_status_in == StatusUnderflow)),
    .count(cnt_unf_out)
  );

  status_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_inx (
    .clk  (clock100KHz),
    .rst  (reset),
    .clear(clear_cnt),
    .inc  (capture && (fpu_status_in == StatusInexact)),
    .count(cnt_inx_out)
  );

  assign in_ready       = (state_q == StIdle);
  assign res_valid      = (state_q == StHold);
  assign op_A_out       = op_a_q;
  assign op_B_out       = op_b_q;
  assign res_data_out   = res_data_q;
  assign res_status_out = res_status_q;
  assign res_flags_out  = res_flag_q;
  assign status_err_out = status_err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer: directed scenarios plus randomized traffic
// against a behavioural FPU stand-in and a counter/latency reference model.
module tb_fpu_op_sequencer;

  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [31:0]   a_in, b_in;
  logic          in_valid, in_ready;
  logic [31:0]   op_A_out, op_B_out;
  logic [31:0]   fpu_data_in;
  logic [3:0]    fpu_status_in;
  logic          fpu_flags_in;
  logic [31:0]   res_data_out;
  logic [3:0]    res_status_out;
  logic          res_flags_out;
  logic          res_valid, res_ready;
  logic          clear_cnt;
  logic [CW-1:0] cnt_exact_out, cnt_ovf_out, cnt_unf_out, cnt_inx_out;
  logic          status_err_out;

  fpu_op_sequencer #(
    .LATENCY(LAT),
    .CNT_W  (CW)
  ) dut (
    .clock100KHz   (clk),
    .reset         (reset),
    .a_in          (a_in),
    .b_in          (b_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_A_out      (op_A_out),
    .op_B_out      (op_B_out),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .fpu_flags_in  (fpu_flags_in),
    .res_data_out  (res_data_out),
    .res_status_out(res_status_out),
    .res_flags_out (res_flags_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .clear_cnt     (clear_cnt),
    .cnt_exact_out (cnt_exact_out),
    .cnt_ovf_out   (cnt_ovf_out),
    .cnt_unf_out   (cnt_unf_out),
    .cnt_inx_out   (cnt_inx_out),
    .status_err_out(status_err_out)
  );

  // Behavioural FPU stand-in: 1.0 + 2.0 = 3.0, otherwise an arbitrary mix.
  function automatic logic [31:0] fpu_data_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + {b[15:0], b[31:16]};
  endfunction

  function automatic logic fpu_flag_fn(input logic [31:0] a, input logic [31:0] b);
    return ^(a & b);
  endfunction

  function automatic int status_idx(input logic [3:0] s);
    case (s)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  logic [3:0] fpu_status_drv;
  assign fpu_data_in   = fpu_data_fn(op_A_out, op_B_out);
  assign fpu_flags_in  = fpu_flag_fn(op_A_out, op_B_out);
  assign fpu_status_in = fpu_status_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    logic        flag;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt[4];
  logic        m_err;
  logic [31:0] m_op_a, m_op_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready / clear driver, placed after the main thread's #1 updates.
  bit rdy_random = 0, rdy_forced = 1, clr_random = 0, clr_forced = 0;
  initial begin
    res_ready = 1'b1;
    clear_cnt = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      res_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_forced;
      clear_cnt = clr_random ? ($urandom_range(0, 15) == 0) : clr_forced;
    end
  end

  logic clr_seen = 1'b0;
  always @(posedge clk) clr_seen <= clear_cnt;

  // Monitor: pops the scoreboard on each new result and tracks counters.
  logic        prev_valid = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_st;
  logic        held_flag;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (clr_seen) begin
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_err = 1'b0;
        end
        if (res_valid && !prev_valid) begin
          if (q.size() == 0) begin
            chk("spurious_result_queue_size", q.size(), 1);
          end else begin
            exp_t e;
            int   idx;
            e = q.pop_front();
            chk("res_data", res_data_out, e.data);
            chk("res_status", res_status_out, e.status);
            chk("res_flag", res_flags_out, e.flag);
            chk("latency", cyc - e.acc, LAT);
            if (!clr_seen) begin
              idx = status_idx(e.status);
              if (idx < 0) m_err = 1'b1;
              else if (m_cnt[idx] < CMAX) m_cnt[idx]++;
            end
          end
          held_data = res_data_out;
          held_st   = res_status_out;
          held_flag = res_flags_out;
        end else if (res_valid) begin
          chk("hold_data_stable", res_data_out, held_data);
          chk("hold_status_stable", res_status_out, held_st);
          chk("hold_flag_stable", res_flags_out, held_flag);
        end
        chk("ready_valid_exclusive", in_ready & res_valid, 0);
        chk("op_a", op_A_out, m_op_a);
        chk("op_b", op_B_out, m_op_b);
        chk("cnt_exact", cnt_exact_out, m_cnt[0]);
        chk("cnt_ovf", cnt_ovf_out, m_cnt[1]);
        chk("cnt_unf", cnt_unf_out, m_cnt[2]);
        chk("cnt_inx", cnt_inx_out, m_cnt[3]);
        chk("status_err", status_err_out, m_err);
        prev_valid = res_valid;
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err      = 1'b0;
    m_op_a     = '0;
    m_op_b     = '0;
    prev_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_a", op_A_out, 0);
    chk("rst_op_b", op_B_out, 0);
    chk("rst_res_data", res_data_out, 0);
    chk("rst_res_status", res_status_out, 0);
    chk("rst_res_flag", res_flags_out, 0);
    chk("rst_cnts", {cnt_exact_out, cnt_ovf_out, cnt_unf_out, cnt_inx_out}, 0);
    chk("rst_status_err", status_err_out, 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] st);
    int waited = 0;
    bit acc = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1;
      end else begin
        waited++;
        if (waited > 60) begin
          chk("issue_timeout_in_ready", in_ready, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid       = 1'b0;
    a_in           = $urandom;
    b_in           = $urandom;
    fpu_status_drv = st;
    m_op_a         = a;
    m_op_b         = b;
    q.push_back('{data: fpu_data_fn(a, b), status: st, flag: fpu_flag_fn(a, b), acc: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || res_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr_forced = 1;
    @(posedge clk);
    #1;
    clr_forced = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] snap_cnt;
    logic [31:0]   snap_data;
    int            n;
    reset          = 1'b1;
    in_valid       = 1'b0;
    a_in           = '0;
    b_in           = '0;
    fpu_status_drv = 4'b0001;
    do_reset();

    // Single operation with visible latency
    issue(32'h3F800000, 32'h40000000, 4'b0001);
    @(negedge clk);
    chk("single_op_a", op_A_out, 32'h3F800000);
    chk("single_op_b", op_B_out, 32'h40000000);
    repeat (3) begin
      @(negedge clk);
      chk("single_not_yet_valid", res_valid, 0);
    end
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data_out, 32'h40400000);
    chk("single_status", res_status_out, 4'b0001);
    chk("single_cnt_exact", cnt_exact_out, 1);
    drain();

    // Backpressure
    rdy_forced = 0;
    issue($urandom, $urandom, 4'b1000);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", res_valid, 1);
    snap_data = res_data_out;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data_stable", res_data_out, snap_data);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_valid_held", res_valid, 1);
    end
    @(posedge clk);
    #1;
    rdy_forced = 1;
    @(posedge clk);
    #1;
    rdy_forced = 0;
    @(negedge clk);
    chk("bp_back_to_idle", in_ready, 1);
    chk("bp_valid_dropped", res_valid, 0);
    rdy_forced = 1;
    drain();

    // Non-one-hot status
    snap_cnt = cnt_exact_out;
    issue($urandom, $urandom, 4'b0110);
    drain();
    @(negedge clk);
    chk("bad_status_err", status_err_out, 1);
    chk("bad_status_exact_unchanged", cnt_exact_out, snap_cnt);
    @(posedge clk);
    #1;
    pulse_clear();
    @(negedge clk);
    chk("bad_status_cleared", status_err_out, 0);
    @(posedge clk);
    #1;

    // Saturation, then clear racing a capture
    repeat (4) issue($urandom, $urandom, 4'b0010);
    drain();
    @(negedge clk);
    chk("sat_ovf_3", cnt_ovf_out, 3);
    @(posedge clk);
    #1;
    issue($urandom, $urandom, 4'b0010);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    clr_forced = 1;
    @(posedge clk);
    #1;
    clr_forced = 0;
    @(negedge clk);
    chk("race_valid", res_valid, 1);
    chk("race_ovf_cleared", cnt_ovf_out, 0);
    drain();

    // Reset mid-operation
    issue($urandom, $urandom, 4'b0100);
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
    repeat (6) begin
      @(negedge clk);
      chk("abandoned_no_valid", res_valid, 0);
    end
    @(posedge clk);
    #1;
    issue($urandom, $urandom, 4'b0100);
    drain();
    chk("post_reset_cnt_unf", cnt_unf_out, 1);

    // Randomized traffic
    rdy_random = 1;
    clr_random = 1;
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      logic [3:0]  st;
      r  = $urandom_range(0, 5);
      st = (r < 4) ? 4'(1 << r) : 4'($urandom);
      issue($urandom, $urandom, st);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_random = 0;
    clr_random = 0;
    rdy_forced = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
